// File: rtl/gpr_pkg.sv
// -----------------------------------------------------------------------------
// gpr_pkg
// Shared definitions for the general-purpose register file and its busy
// scoreboard: default geometry, the register-0 address constant, and the
// byte-merge rule used by both the write path and the write-through bypass.
// -----------------------------------------------------------------------------
package gpr_pkg;

  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned AW_DEF   = 5;
  localparam int unsigned REG_ZERO = 0;

  // One byte lane of the A/B merge: port B has priority when both strobe
  // the same byte, otherwise whichever port strobes it, otherwise old data.
  function automatic logic [7:0] merge_byte(
    input logic [7:0] old_byte,
    input logic       a_we,
    input logic [7:0] a_byte,
    input logic       b_we,
    input logic [7:0] b_byte
  );
    logic [7:0] res;
    if (b_we) begin
      res = b_byte;
    end else if (a_we) begin
      res = a_byte;
    end else begin
      res = old_byte;
    end
    return res;
  endfunction

endpackage

// File: rtl/gpr_file_sb_tracker.sv
// -----------------------------------------------------------------------------
// gpr_sb_tracker
// Per-register busy scoreboard. Tracks which registers have an outstanding
// producer, accepts issues (iss_rdy_o), retires entries on clearing writes and
// keeps a registered count of busy registers. No data path.
//   clk, rst             : clock, async active-low reset
//   wX_en_i/addr_i/clr_i : write-port qualifiers; en & clr retires wX_addr
//   iss_en_i/iss_addr_i  : issue request for a destination register
//   rd_addr_i            : read-port addresses (busy lookup)
//   rd_busy_o            : busy bit per read port
//   iss_rdy_o            : issue accepted this cycle
//   busy_cnt_o           : number of busy registers
// -----------------------------------------------------------------------------
module gpr_sb_tracker
  import gpr_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wa_en_i,
  input  logic [AW-1:0]     wa_addr_i,
  input  logic              wa_clr_i,
  input  logic              wb_en_i,
  input  logic [AW-1:0]     wb_addr_i,
  input  logic              wb_clr_i,
  input  logic              iss_en_i,
  input  logic [AW-1:0]     iss_addr_i,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD-1:0]    rd_busy_o,
  output logic              iss_rdy_o,
  output logic [AW:0]       busy_cnt_o
);

  localparam int NREG = 2 ** AW;

  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     busy_cnt_q, busy_cnt_d;
  logic            clr_a, clr_b, iss_zero, iss_clr_hit, iss_set;
  logic            cnt_inc, cnt_dec_a, cnt_dec_b;

  // Issue acceptance, set/clear arbitration and the net change of the count.
  always_comb begin
    clr_a       = wa_en_i & wa_clr_i;
    clr_b       = wb_en_i & wb_clr_i;
    iss_zero    = (ZERO_REG != 0) && (iss_addr_i == AW'(REG_ZERO));
    iss_clr_hit = (clr_a && (wa_addr_i == iss_addr_i)) ||
                  (clr_b && (wb_addr_i == iss_addr_i));
    iss_rdy_o   = iss_en_i & (iss_zero | ~busy_q[iss_addr_i] | iss_clr_hit);
    iss_set     = iss_rdy_o & ~iss_zero;

    // Clears first, then the set, so a new producer outlives the retiring one.
    busy_d             = busy_q;
    busy_d[wa_addr_i]  = busy_d[wa_addr_i] & ~clr_a;
    busy_d[wb_addr_i]  = busy_d[wb_addr_i] & ~clr_b;
    busy_d[iss_addr_i] = busy_d[iss_addr_i] | iss_set;

    // Only bits that really flip move the count; a clear masked by a set on
    // the same register, or a duplicate A/B clear, contributes nothing.
    cnt_inc   = iss_set & ~busy_q[iss_addr_i];
    cnt_dec_a = clr_a & busy_q[wa_addr_i] & ~(iss_set && (iss_addr_i == wa_addr_i));
    cnt_dec_b = clr_b & busy_q[wb_addr_i] & ~(iss_set && (iss_addr_i == wb_addr_i))
              & ~(clr_a && (wa_addr_i == wb_addr_i));
    busy_cnt_d = busy_cnt_q + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec_a) - (AW+1)'(cnt_dec_b);
  end

  // Scoreboard state and busy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt_o = busy_cnt_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd_busy
    logic [AW-1:0] ra;
    logic          clr_hit;
    assign ra      = rd_addr_i[k*AW +: AW];
    assign clr_hit = (clr_a && (wa_addr_i == ra)) || (clr_b && (wb_addr_i == ra));
    // With write-through, a retiring producer already looks done to readers.
    assign rd_busy_o[k] = busy_q[ra] & ~((BYPASS != 0) & clr_hit);
  end

endmodule

// File: rtl/gpr_file_sb.sv
// -----------------------------------------------------------------------------
// gpr_file_sb
// General-purpose register file with NRD combinational read ports, two
// byte-strobed synchronous write ports (A: ALU/writeback, B: load return,
// B wins on overlapping bytes), optional write-through bypass and an
// integrated busy scoreboard for RAW/WAW stall detection.
//   clk, rst                  : clock, async active-low reset
//   rd_addr_i / rd_data_o     : packed read addresses / data, port k in slice k
//   rd_busy_o                 : busy bit of each read address
//   wX_en_i/addr_i/be_i/data_i: write port X, byte strobes per DW/8 lanes
//   wX_clr_i                  : write also retires the scoreboard entry
//   iss_en_i/iss_addr_i       : issue request; iss_rdy_o accepts it
//   busy_cnt_o                : number of busy registers
// -----------------------------------------------------------------------------
module gpr_file_sb
  import gpr_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD*DW-1:0] rd_data_o,
  output logic [NRD-1:0]    rd_busy_o,
  input  logic              wa_en_i,
  input  logic [AW-1:0]     wa_addr_i,
  input  logic [DW/8-1:0]   wa_be_i,
  input  logic [DW-1:0]     wa_data_i,
  input  logic              wa_clr_i,
  input  logic              wb_en_i,
  input  logic [AW-1:0]     wb_addr_i,
  input  logic [DW/8-1:0]   wb_be_i,
  input  logic [DW-1:0]     wb_data_i,
  input  logic              wb_clr_i,
  input  logic              iss_en_i,
  input  logic [AW-1:0]     iss_addr_i,
  output logic              iss_rdy_o,
  output logic [AW:0]       busy_cnt_o
);

  localparam int NB   = DW / 8;
  localparam int NREG = 2 ** AW;

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic          wa_we, wb_we;

  // Effective write enables: writes to the hardwired zero register are
  // dropped, and nothing is written or bypassed while reset is held.
  assign wa_we = wa_en_i & rst & ~((ZERO_REG != 0) && (wa_addr_i == AW'(REG_ZERO)));
  assign wb_we = wb_en_i & rst & ~((ZERO_REG != 0) && (wb_addr_i == AW'(REG_ZERO)));

  // Next register contents: per-byte A/B merge for every register.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      for (int j = 0; j < NB; j++) begin
        regs_d[r][8*j +: 8] = merge_byte(regs_q[r][8*j +: 8],
                                         wa_we & (wa_addr_i == AW'(r)) & wa_be_i[j],
                                         wa_data_i[8*j +: 8],
                                         wb_we & (wb_addr_i == AW'(r)) & wb_be_i[j],
                                         wb_data_i[8*j +: 8]);
      end
    end
  end

  // Register storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] rdata;
    assign ra = rd_addr_i[k*AW +: AW];

    // Read mux, optionally with same-cycle write data merged in.
    always_comb begin
      rdata = regs_q[ra];
      if (BYPASS != 0) begin
        for (int j = 0; j < NB; j++) begin
          rdata[8*j +: 8] = merge_byte(regs_q[ra][8*j +: 8],
                                       wa_we & (wa_addr_i == ra) & wa_be_i[j],
                                       wa_data_i[8*j +: 8],
                                       wb_we & (wb_addr_i == ra) & wb_be_i[j],
                                       wb_data_i[8*j +: 8]);
        end
      end else begin
        rdata = regs_q[ra];
      end
    end

    assign rd_data_o[k*DW +: DW] =
      ((ZERO_REG != 0) && (ra == AW'(REG_ZERO))) ? {DW{1'b0}} : rdata;
  end

  gpr_sb_tracker #(
    .AW       (AW),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .wa_en_i    (wa_en_i),
    .wa_addr_i  (wa_addr_i),
    .wa_clr_i   (wa_clr_i),
    .wb_en_i    (wb_en_i),
    .wb_addr_i  (wb_addr_i),
    .wb_clr_i   (wb_clr_i),
    .iss_en_i   (iss_en_i),
    .iss_addr_i (iss_addr_i),
    .rd_addr_i  (rd_addr_i),
    .rd_busy_o  (rd_busy_o),
    .iss_rdy_o  (iss_rdy_o),
    .busy_cnt_o (busy_cnt_o)
  );

endmodule

// File: tb/tb_gpr_file_sb.sv
module tb_gpr_file_sb;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NREG = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NRD*AW-1:0] rd_addr;
  logic              wa_en, wa_clr, wb_en, wb_clr, iss_en;
  logic [AW-1:0]     wa_addr, wb_addr, iss_addr;
  logic [3:0]        wa_be, wb_be;
  logic [DW-1:0]     wa_data, wb_data;

  logic [NRD*DW-1:0] rd_data_bp, rd_data_nb;
  logic [NRD-1:0]    rd_busy_bp, rd_busy_nb;
  logic              iss_rdy_bp, iss_rdy_nb;
  logic [AW:0]       busy_cnt_bp, busy_cnt_nb;

  gpr_file_sb #(.DW(DW), .AW(AW), .NRD(NRD), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_bp), .rd_busy_o(rd_busy_bp),
    .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_be_i(wa_be), .wa_data_i(wa_data), .wa_clr_i(wa_clr),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_be_i(wb_be), .wb_data_i(wb_data), .wb_clr_i(wb_clr),
    .iss_en_i(iss_en), .iss_addr_i(iss_addr), .iss_rdy_o(iss_rdy_bp), .busy_cnt_o(busy_cnt_bp));

  gpr_file_sb #(.DW(DW), .AW(AW), .NRD(NRD), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_nb), .rd_busy_o(rd_busy_nb),
    .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_be_i(wa_be), .wa_data_i(wa_data), .wa_clr_i(wa_clr),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_be_i(wb_be), .wb_data_i(wb_data), .wb_clr_i(wb_clr),
    .iss_en_i(iss_en), .iss_addr_i(iss_addr), .iss_rdy_o(iss_rdy_nb), .busy_cnt_o(busy_cnt_nb));

  int checks = 0;
  int errors = 0;

  // Reference model: architectural register contents and busy set.
  logic [DW-1:0]   m_mem [NREG];
  logic [NREG-1:0] m_busy;

  typedef struct {
    logic          wa_en; logic [AW-1:0] wa_addr; logic [3:0] wa_be; logic [DW-1:0] wa_data; logic wa_clr;
    logic          wb_en; logic [AW-1:0] wb_addr; logic [3:0] wb_be; logic [DW-1:0] wb_data; logic wb_clr;
    logic          iss_en; logic [AW-1:0] iss_addr; logic [AW-1:0] rd0;
    logic [DW-1:0] exp_d0; logic [DW-1:0] exp_d0_nb; logic exp_b0; logic exp_rdy; logic [AW:0] exp_cnt;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Value a reader sees at address a: stored contents, plus this cycle's
  // strobed bytes when write-through is on (port B applied last, so it wins).
  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a, input bit bp);
    logic [DW-1:0] v;
    v = m_mem[a];
    if (a == 0) return '0;
    if (bp) begin
      for (int j = 0; j < 4; j++) begin
        if (wa_en && wa_addr == a && wa_be[j]) v[8*j +: 8] = wa_data[8*j +: 8];
        if (wb_en && wb_addr == a && wb_be[j]) v[8*j +: 8] = wb_data[8*j +: 8];
      end
    end
    return v;
  endfunction

  function automatic bit m_clearing(input logic [AW-1:0] a);
    return (wa_en && wa_clr && wa_addr == a) || (wb_en && wb_clr && wb_addr == a);
  endfunction

  function automatic int m_popcnt();
    int c = 0;
    for (int i = 0; i < NREG; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic idle();
    wa_en = 1'b0; wa_addr = '0; wa_be = '0; wa_data = '0; wa_clr = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_be = '0; wb_data = '0; wb_clr = 1'b0;
    iss_en = 1'b0; iss_addr = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_mem[i] = '0;
    m_busy = '0;
  endtask

  // Compare all outputs of both instances against the model, then advance
  // the model across the next rising edge. Called at posedge+1.
  task automatic cycle();
    logic [DW-1:0]   na, nb;
    logic [NREG-1:0] nbusy;
    logic [AW-1:0]   ra;
    bit              rdy;
    #3;
    for (int k = 0; k < NRD; k++) begin
      ra = rd_addr[k*AW +: AW];
      chk($sformatf("rd_data_bp%0d", k), 64'(rd_data_bp[k*DW +: DW]), 64'(m_read(ra, 1'b1)));
      chk($sformatf("rd_data_nb%0d", k), 64'(rd_data_nb[k*DW +: DW]), 64'(m_read(ra, 1'b0)));
      chk($sformatf("rd_busy_bp%0d", k), 64'(rd_busy_bp[k]), 64'(m_busy[ra] & !m_clearing(ra)));
      chk($sformatf("rd_busy_nb%0d", k), 64'(rd_busy_nb[k]), 64'(m_busy[ra]));
    end
    rdy = iss_en && (iss_addr == 0 || !m_busy[iss_addr] || m_clearing(iss_addr));
    chk("iss_rdy_bp", 64'(iss_rdy_bp), 64'(rdy));
    chk("iss_rdy_nb", 64'(iss_rdy_nb), 64'(rdy));
    chk("busy_cnt_bp", 64'(busy_cnt_bp), 64'(m_popcnt()));
    chk("busy_cnt_nb", 64'(busy_cnt_nb), 64'(m_popcnt()));
    na = m_read(wa_addr, 1'b1);
    nb = m_read(wb_addr, 1'b1);
    nbusy = m_busy;
    if (wa_en && wa_clr) nbusy[wa_addr] = 1'b0;
    if (wb_en && wb_clr) nbusy[wb_addr] = 1'b0;
    if (rdy && iss_addr != 0) nbusy[iss_addr] = 1'b1;
    @(posedge clk);
    #1;
    m_mem[wa_addr] = na;
    m_mem[wb_addr] = nb;
    m_mem[0] = '0;
    m_busy = nbusy;
  endtask

  function automatic vec_t mk(
    input logic a_en, input logic [AW-1:0] a_ad, input logic [3:0] a_be, input logic [DW-1:0] a_d, input logic a_clr,
    input logic b_en, input logic [AW-1:0] b_ad, input logic [3:0] b_be, input logic [DW-1:0] b_d, input logic b_clr,
    input logic i_en, input logic [AW-1:0] i_ad, input logic [AW-1:0] r0,
    input logic [DW-1:0] e_d, input logic [DW-1:0] e_nb, input logic e_b, input logic e_r, input logic [AW:0] e_c);
    vec_t v;
    v.wa_en = a_en; v.wa_addr = a_ad; v.wa_be = a_be; v.wa_data = a_d; v.wa_clr = a_clr;
    v.wb_en = b_en; v.wb_addr = b_ad; v.wb_be = b_be; v.wb_data = b_d; v.wb_clr = b_clr;
    v.iss_en = i_en; v.iss_addr = i_ad; v.rd0 = r0;
    v.exp_d0 = e_d; v.exp_d0_nb = e_nb; v.exp_b0 = e_b; v.exp_rdy = e_r; v.exp_cnt = e_c;
    return v;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREG - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    model_reset();
    idle();
    // Reset state, with a write and an issue pending against it.
    wa_en = 1'b1; wa_addr = 5'd3; wa_be = 4'hF; wa_data = 32'hDEADBEEF;
    iss_en = 1'b1; iss_addr = 5'd5;
    rd_addr = {5'd31, 5'd3};
    #3;
    chk("rst_rd_data_bp", 64'(rd_data_bp), 64'd0);
    chk("rst_rd_data_nb", 64'(rd_data_nb), 64'd0);
    chk("rst_rd_busy", 64'({rd_busy_bp, rd_busy_nb}), 64'd0);
    chk("rst_busy_cnt", 64'(busy_cnt_bp), 64'd0);
    chk("rst_iss_rdy", 64'(iss_rdy_bp), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle();
    for (int i = 0; i < NREG; i++) begin
      rd_addr = {AW'(NREG - 1 - i), AW'(i)};
      cycle();
    end

    // Asynchronous reset in the middle of a write to a busy register.
    wa_en = 1'b1; wa_addr = 5'd3; wa_be = 4'hF; wa_data = 32'h12345678;
    iss_en = 1'b1; iss_addr = 5'd3; rd_addr = {5'd0, 5'd3};
    cycle();
    idle();
    wa_en = 1'b1; wa_addr = 5'd3; wa_be = 4'hF; wa_data = 32'hDEADBEEF;
    #2 rst = 1'b0;
    #1;
    chk("arst_rd_data", 64'(rd_data_bp[31:0]), 64'd0);
    chk("arst_rd_busy", 64'(rd_busy_bp[0]), 64'd0);
    chk("arst_busy_cnt", 64'(busy_cnt_bp), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle();
    model_reset();
    #3;
    chk("arst_r3_after", 64'(rd_data_bp[31:0]), 64'd0);
    #1;
    @(posedge clk);
    #1;

    // Directed vectors.
    vecs.push_back(mk(1, 5, 4'hF, 32'hAABBCCDD, 0, 0, 0, 0, 0, 0, 0, 0, 5, 32'hAABBCCDD, 32'h0, 0, 0, 0));
    vecs.push_back(mk(1, 5, 4'h3, 32'h11223344, 0, 0, 0, 0, 0, 0, 0, 0, 5, 32'hAABB3344, 32'hAABBCCDD, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 32'hAABB3344, 32'hAABB3344, 0, 0, 0));
    vecs.push_back(mk(1, 7, 4'hF, 32'h01020304, 0, 1, 7, 4'hC, 32'hF0F0F0F0, 0, 0, 0, 7, 32'hF0F00304, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 32'hF0F00304, 32'hF0F00304, 0, 0, 0));
    vecs.push_back(mk(1, 0, 4'hF, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 32'h0, 32'h0, 0, 1, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, 4'h0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 32'h0, 32'h0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 32'h0, 0, 1, 9, 4'hF, 32'h12345678, 1, 1, 9, 9, 32'h12345678, 32'h0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 4'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 32'h12345678, 32'h12345678, 1, 0, 1));
    vecs.push_back(mk(1, 9, 4'h0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 9, 32'h12345678, 32'h12345678, 0, 0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h0, 32'h0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 32'h0, 32'h0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 4'h0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 32'h0, 32'h0, 1, 1, 2));
    vecs.push_back(mk(0, 0, 4'h0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 4, 1, 32'h0, 32'h0, 1, 1, 3));
    vecs.push_back(mk(1, 1, 4'h0, 32'h0, 1, 1, 2, 4'h0, 32'h0, 1, 1, 6, 1, 32'h0, 32'h0, 0, 1, 4));
    vecs.push_back(mk(0, 3, 4'hF, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 0, 0, 3, 32'h0, 32'h0, 1, 0, 3));
    vecs.push_back(mk(0, 0, 4'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 32'h0, 32'h0, 1, 0, 3));

    foreach (vecs[i]) begin
      wa_en = vecs[i].wa_en; wa_addr = vecs[i].wa_addr; wa_be = vecs[i].wa_be;
      wa_data = vecs[i].wa_data; wa_clr = vecs[i].wa_clr;
      wb_en = vecs[i].wb_en; wb_addr = vecs[i].wb_addr; wb_be = vecs[i].wb_be;
      wb_data = vecs[i].wb_data; wb_clr = vecs[i].wb_clr;
      iss_en = vecs[i].iss_en; iss_addr = vecs[i].iss_addr;
      rd_addr = {5'd0, vecs[i].rd0};
      #2;
      chk($sformatf("tv%0d_d0", i), 64'(rd_data_bp[31:0]), 64'(vecs[i].exp_d0));
      chk($sformatf("tv%0d_d0_nb", i), 64'(rd_data_nb[31:0]), 64'(vecs[i].exp_d0_nb));
      chk($sformatf("tv%0d_busy0", i), 64'(rd_busy_bp[0]), 64'(vecs[i].exp_b0));
      chk($sformatf("tv%0d_rdy", i), 64'(iss_rdy_bp), 64'(vecs[i].exp_rdy));
      chk($sformatf("tv%0d_cnt", i), 64'(busy_cnt_bp), 64'(vecs[i].exp_cnt));
      cycle();
    end

    // Randomized soak against the model.
    for (int n = 0; n < 10000; n++) begin
      wa_en = 1'($urandom_range(0, 1)); wa_addr = rand_addr(); wa_be = 4'($urandom);
      wa_data = $urandom; wa_clr = 1'($urandom_range(0, 1));
      wb_en = 1'($urandom_range(0, 1)); wb_addr = rand_addr(); wb_be = 4'($urandom);
      wb_data = $urandom; wb_clr = 1'($urandom_range(0, 1));
      iss_en = 1'($urandom_range(0, 1)); iss_addr = rand_addr();
      rd_addr = {rand_addr(), rand_addr()};
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpr_file_sb.md
Name: gpr_file_sb

Overview:
Parametrised general-purpose register file for the next CPU generation. It provides NRD combinational read ports and two synchronous write ports. Port A carries ALU/writeback results; port B carries load returns. Each write port has byte strobes and optional write-through bypass. An integrated per-register busy scoreboard gives the control FSM RAW/WAW stall information, with an issue handshake.

Parameters:
DW, 32, data width in bits; must be a multiple of 8
AW, 5, register address width; depth = 2**AW
NRD, 2, number of read ports
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy
BYPASS, 1, 1 = read data reflects same-cycle writes (write-through)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
rd_addr  in  NRD*AW  read addresses; port k = bits [k*AW +: AW]
rd_data  out  NRD*DW  read data, port k = bits [k*DW +: DW]
rd_busy  out  NRD  busy bit of each read address
wa_en  in  1  write port A enable
wa_addr  in  AW  write port A address
wa_be  in  DW/8  write port A byte strobes
wa_data  in  DW  write port A data
wa_clr  in  1  port A write also retires scoreboard entry
wb_en, wb_addr, wb_be, wb_data, wb_clr  in  (same widths)  write port B, same meanings
iss_en  in  1  request to mark iss_addr busy (instruction issue)
iss_addr  in  AW  destination register of the issuing instruction
iss_rdy  out  1  issue accepted this cycle
busy_cnt  out  AW+1  number of registers currently busy

Behaviour:
- Reset (rst=0, async): all registers = 0, all busy bits = 0, busy_cnt = 0. Reset mid-operation discards pending writes and issues on that edge. Outputs are combinational from the cleared state: rd_data = 0, rd_busy = 0, iss_rdy = 1.
- Write, posedge clk: for each byte j with wX_en & wX_be[j], reg[wX_addr] byte j <= wX_data byte j. A byte with be=0 keeps its old value.
- Both ports to the same address: bytes strobed on only one port take that port's data. Bytes strobed on both ports take port B.
- ZERO_REG=1: writes to address 0 are ignored, and reads of address 0 return 0 regardless of BYPASS.
- Read: combinational, zero latency; rd_data_k = reg[rd_addr_k].
- BYPASS=1: any byte being written this cycle to rd_addr_k is returned as the new value, with the same A/B merge rule as the write path.
- BYPASS=0: reads always return the pre-edge register contents.
- Scoreboard, busy[2**AW]:
  - Clear: at posedge, wX_en & wX_clr clears busy[wX_addr]. wX_clr is ignored when wX_en=0.
  - iss_rdy = iss_en & (busy[iss_addr]==0 or a clearing write to iss_addr this cycle). This blocks WAW hazards.
  - iss_addr=0 with ZERO_REG=1: iss_rdy = iss_en, and no bit is set.
  - Set: iss_en & iss_rdy sets busy[iss_addr] at posedge. When set and clear hit the same register in the same cycle, set wins (a new producer replaces the retiring one).
  - iss_en & !iss_rdy: no state change. The requester holds iss_en/iss_addr until accepted.
  - rd_busy_k = busy[rd_addr_k] & !(a clearing write to rd_addr_k this cycle with BYPASS=1). With BYPASS=0 it reports the raw busy bit.
- busy_cnt: registered, updated each edge with the net of the sets and clears that actually change a bit (range -2..+1 per cycle). It always equals the popcount of busy and never exceeds 2**AW.

Decomposition:
- Shared package gpr_pkg: DW/AW defaults, function for the byte-merge of A/B data, and the register-0 constant.
- One natural sub-module, gpr_sb_tracker: busy bits, iss_rdy, set/clear arbitration, busy_cnt. It has no data path.
- Storage, merge and bypass stay in the top module.

Test Plan:
- Reset then read all addresses -> rd_data 0, rd_busy 0, busy_cnt 0. Assert rst mid-write of 0xDEADBEEF to r3 -> r3 stays 0.
- wa_en, addr 5, be=4'b0011, data 0x11223344 over old 0xAABBCCDD -> r5 = 0xAABB3344 next cycle. Same cycle read of r5 with BYPASS=1 -> 0xAABB3344; with BYPASS=0 -> 0xAABBCCDD.
- Same-cycle A(addr 7, be 1111, 0x01020304) and B(addr 7, be 1100, 0xF0F0F0F0) -> r7 = 0xF0F00304. Write to r0 with data 0xFFFFFFFF -> read 0.
- iss r9 -> iss_rdy=1, busy_cnt=1, rd_busy for r9 = 1. Second iss r9 -> iss_rdy=0, held for 3 cycles. wb_en/wb_clr to r9 -> iss_rdy=1 same cycle, busy stays 1, busy_cnt stays 1.
- Issue r1 to r4 on successive cycles, then same-cycle clears of r1 (port A) and r2 (port B) plus issue r6 -> busy_cnt 4 -> 3. Clear with wa_en=0, wa_clr=1 -> no change.
- Random 10k-cycle soak against a reference model: rd_data, rd_busy and busy_cnt match the model every cycle, and busy_cnt equals the popcount of the busy bits.
